// File: rtl/mat_diag_engine.sv
// -----------------------------------------------------------------------------
// mat_diag_engine
//   Streams in a weight matrix W and then an input matrix X (2x2 or 4x4,
//   signed, row-major), forms P = X * W one element per cycle, accumulates each
//   P[i][j] into anti-diagonal sum D[i+j], and streams D[0..2n-2] out.
//
// Ports
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-high reset
//   in_valid     : qualifies matrix, high for 2n^2 consecutive cycles per job
//   matrix       : one signed element per in_valid cycle (W first, then X)
//   matrix_size  : 0 = 2x2, 1 = 4x4, sampled on the first element only
//   out_valid    : high for 2n-1 consecutive cycles per job (registered)
//   out_value    : anti-diagonal sum, 0 whenever out_valid is low (registered)
// -----------------------------------------------------------------------------
module mat_diag_engine #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 40,
  parameter int MAX_N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] matrix,
  input  logic              matrix_size,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_value
);

  localparam int IDX_W = $clog2(MAX_N);
  localparam int K_W   = $clog2(2 * MAX_N);
  localparam int NDIAG = 2 * MAX_N - 1;
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_X = 3'd2,
    CALC   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t                   state_q;
  logic                     size_q;
  logic [IDX_W-1:0]         row_q;
  logic [IDX_W-1:0]         col_q;
  logic [K_W-1:0]           k_q;
  logic signed [DATA_W-1:0] w_q [MAX_N][MAX_N];
  logic signed [DATA_W-1:0] x_q [MAX_N][MAX_N];
  logic signed [OUT_W-1:0]  diag_q [NDIAG];
  logic                     out_valid_q;
  logic [OUT_W-1:0]         out_value_q;

  logic [IDX_W-1:0]         last_idx_d;
  logic [K_W-1:0]           num_out_d;
  logic [K_W-1:0]           diag_idx_d;
  logic                     at_last_d;
  logic [IDX_W-1:0]         row_d;
  logic [IDX_W-1:0]         col_d;
  logic signed [OUT_W-1:0]  p_elem_d;

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

  // Matrix geometry for the job in flight and the next row-major position.
  always_comb begin
    last_idx_d = size_q ? IDX_W'(MAX_N - 1) : IDX_W'(1'b1);
    num_out_d  = size_q ? K_W'(2 * MAX_N - 1) : K_W'(2'd3);
    diag_idx_d = K_W'(row_q) + K_W'(col_q);
    at_last_d  = (row_q == last_idx_d) && (col_q == last_idx_d);
    if (col_q == last_idx_d) begin
      col_d = '0;
      row_d = row_q + IDX_W'(1'b1);
    end else begin
      col_d = col_q + IDX_W'(1'b1);
      row_d = row_q;
    end
  end

  // Dot product of X row row_q with W column col_q; terms beyond n are masked
  // because a 2x2 job may follow a 4x4 job that left stale data there.
  always_comb begin
    logic signed [PW-1:0] prod_v;
    int                   active_n;
    p_elem_d = '0;
    prod_v   = '0;
    active_n = size_q ? MAX_N : 2;
    for (int m = 0; m < MAX_N; m++) begin
      prod_v = x_q[row_q][IDX_W'(m)] * w_q[IDX_W'(m)][col_q];
      if (m < active_n) begin
        p_elem_d = p_elem_d + {{(OUT_W - PW){prod_v[PW-1]}}, prod_v};
      end else begin
        p_elem_d = p_elem_d;
      end
    end
  end

  // Job sequencer: load W, load X, compute P into diagonals, stream results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      for (int r = 0; r < MAX_N; r++) begin
        for (int c = 0; c < MAX_N; c++) begin
          w_q[r][c] <= '0;
          x_q[r][c] <= '0;
        end
      end
      for (int d = 0; d < NDIAG; d++) begin
        diag_q[d] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_value_q <= '0;
          k_q         <= '0;
          if (in_valid) begin
            // First element is W[0][0]; continue loading from (0,1).
            size_q    <= matrix_size;
            w_q[0][0] <= matrix;
            row_q     <= '0;
            col_q     <= IDX_W'(1'b1);
            for (int d = 0; d < NDIAG; d++) begin
              diag_q[d] <= '0;
            end
            state_q   <= LOAD_W;
          end else begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= IDLE;
          end
        end

        LOAD_W: begin
          if (!in_valid) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= IDLE;
          end else if (at_last_d) begin
            w_q[row_q][col_q] <= matrix;
            row_q             <= '0;
            col_q             <= '0;
            state_q           <= LOAD_X;
          end else begin
            w_q[row_q][col_q] <= matrix;
            row_q             <= row_d;
            col_q             <= col_d;
          end
        end

        LOAD_X: begin
          if (!in_valid) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= IDLE;
          end else if (at_last_d) begin
            x_q[row_q][col_q] <= matrix;
            row_q             <= '0;
            col_q             <= '0;
            state_q           <= CALC;
          end else begin
            x_q[row_q][col_q] <= matrix;
            row_q             <= row_d;
            col_q             <= col_d;
          end
        end

        CALC: begin
          diag_q[diag_idx_d] <= diag_q[diag_idx_d] + p_elem_d;
          if (at_last_d) begin
            // D[0] only receives P[0][0], so it is already final here.
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b1;
            out_value_q <= diag_q[0];
            k_q         <= K_W'(1'b1);
            state_q     <= OUT;
          end else begin
            row_q <= row_d;
            col_q <= col_d;
          end
        end

        OUT: begin
          if (k_q == num_out_d) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            k_q         <= '0;
            state_q     <= IDLE;
          end else begin
            out_value_q <= diag_q[k_q];
            k_q         <= k_q + K_W'(1'b1);
          end
        end

        default: begin
          state_q     <= IDLE;
          row_q       <= '0;
          col_q       <= '0;
          k_q         <= '0;
          out_valid_q <= 1'b0;
          out_value_q <= '0;
        end
      endcase
    end
  end

endmodule
